// File: rtl/uio_arb_pkg.sv
// rtl/uio_arb_pkg.sv - shared types, defaults and helpers for the uio bus arbiter
package uio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TURN  = 2'd1,
        GRANT = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_MAX_HOLD   = 8;
    localparam int DEF_TURNAROUND = 1;

    // Width of an index that selects one of n requesters (at least one bit).
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uio_bus_arbiter_rr_picker.sv
// rtl/uio_bus_arbiter_rr_picker.sv - combinational round-robin winner selection
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic          valid,
    output logic [IW-1:0] winner
);

    // Scan from the highest offset down so the request nearest rr_ptr is the last (winning) write.
    always_comb begin
        int pos;
        valid  = |req;
        winner = '0;
        pos    = 0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(rr_ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (req[pos]) begin
                winner = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/uio_bus_arbiter.sv
// rtl/uio_bus_arbiter.sv - round-robin owner arbitration of the shared uio pad group
module uio_bus_arbiter
    import uio_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int MAX_HOLD   = DEF_MAX_HOLD,
    parameter int TURNAROUND = DEF_TURNAROUND
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   dir,
    input  logic [NUM_REQ*8-1:0] wdata,
    input  logic [7:0]           uio_in,
    output logic [7:0]           uio_out,
    output logic [7:0]           uio_oe,
    output logic [NUM_REQ-1:0]   grant,
    output logic [7:0]           rdata,
    output logic                 rvalid
);

    localparam int IW = idx_width(NUM_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int TW = $clog2(TURNAROUND + 1);

    arb_state_e    state_q;
    logic [IW-1:0] owner_q;
    logic          own_dir_q;
    logic [IW-1:0] rr_ptr_q;
    logic [HW-1:0] hold_cnt_q;
    logic [TW-1:0] turn_cnt_q;
    logic [7:0]    rdata_q;
    logic          rvalid_q;

    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] rr_ptr_d;
    logic [7:0]    wd_arr [NUM_REQ];
    logic          drive_en;

    rr_picker #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    // Pointer moves one past the releasing owner so everyone else gets a turn first.
    always_comb begin
        rr_ptr_d = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
    end

    // Arbitration FSM plus registered read path; ena low aborts any ownership.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            own_dir_q  <= 1'b0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            turn_cnt_q <= '0;
            rdata_q    <= 8'h00;
            rvalid_q   <= 1'b0;
        end else if (!ena) begin
            state_q  <= IDLE;
            rvalid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rvalid_q <= 1'b0;
                    if (pick_valid) begin
                        owner_q    <= pick_idx;
                        own_dir_q  <= dir[pick_idx];
                        turn_cnt_q <= '0;
                        state_q    <= TURN;
                    end
                end
                TURN: begin
                    rvalid_q <= 1'b0;
                    if (turn_cnt_q == TW'(TURNAROUND - 1)) begin
                        hold_cnt_q <= '0;
                        state_q    <= GRANT;
                    end else begin
                        turn_cnt_q <= turn_cnt_q + TW'(1);
                    end
                end
                GRANT: begin
                    if (!own_dir_q) begin
                        rdata_q  <= uio_in;
                        rvalid_q <= 1'b1;
                    end else begin
                        rvalid_q <= 1'b0;
                    end
                    if (!req[owner_q] || hold_cnt_q == HW'(MAX_HOLD - 1)) begin
                        hold_cnt_q <= '0;
                        rr_ptr_q   <= rr_ptr_d;
                        state_q    <= IDLE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HW'(1);
                    end
                end
                default: begin
                    rvalid_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    // Split the flat write-data bus into per-requester bytes.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            wd_arr[i] = wdata[8*i +: 8];
        end
    end

    // Pad and grant decode; ena gates everything combinationally.
    always_comb begin
        drive_en = ena && (state_q == GRANT);
        grant    = drive_en ? (NUM_REQ'(1) << owner_q) : '0;
        uio_oe   = (drive_en && own_dir_q) ? 8'hFF : 8'h00;
        uio_out  = (drive_en && own_dir_q) ? wd_arr[owner_q] : 8'h00;
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

endmodule
